alu_stack_issuer: RTL
=====================

Name: alu_stack_issuer

Overview:
- Operand-stack front end that drives the nanoRisc arithmeticUnit and consumes its results and flags.
- Accepts push and operate commands, holds an 8-bit operand stack, and issues operands and opcode to the combinational ALU.
- Captures the ALU result and flags, then writes the result back onto the stack.
- Sits between instruction decode and the ALU; is the producer/consumer end of the ALU's operand/result interface.

Parameters:
DEPTH, 8, stack entries (power of 2, 2..64)
PTR_W, 3, clog2(DEPTH); stack pointer is PTR_W+1 bits wide to hold 0..DEPTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_push  in  1  1 = push cmd_imm; 0 = execute cmd_op
cmd_op  in  4  ALU opcode (nanoRisc encoding)
cmd_imm  in  8  push value, or immediate for linked ops (0001, 0011, 1011, 1101)
cmd_unsigned  in  1  registered, forwarded as alu_unsigned
alu_a, alu_b  out  8  ALU operands
alu_op  out  4  ALU opcode
alu_unsigned  out  1  to ALU en_unsigned
alu_result, alu_remainder  in  8  from ALU
alu_zero, alu_overflow, alu_underflow, alu_divbyzero  in  1  from ALU
alu_comp  in  2  from ALU
done  out  1  one-cycle pulse when a command retires
err  out  2  valid with done: 00 ok, 01 stack overflow, 10 stack underflow, 11 divide by zero
flags  out  4  sticky-until-next-op {zero, overflow, underflow, divbyzero}
comp_flag  out  2  last compare result
depth_cnt  out  PTR_W+1  current number of stack entries

Behaviour:
- Reset values: state = IDLE; sp = 0; all outputs 0 except cmd_ready = 1. Stack RAM contents are not reset.
- Operand roles: TOP = stack[sp-1], NEXT = stack[sp-2].
- Standard binary ops: alu_a = NEXT, alu_b = TOP; need 2 entries.
- Linked ops: alu_a = TOP, alu_b = registered imm; need 1 entry.
- NOT (1110): alu_a = TOP, alu_b = 0; need 1 entry.
- COMP (1111): needs 2 entries; stack is unchanged.
- When not in ISSUE: alu_a/alu_b = 0, alu_op = 0.
- FSM states: IDLE, ISSUE, WRITE.
- IDLE:
  - On cmd_valid: register op, imm, push, unsigned.
  - Push command: if sp == DEPTH, err = 01 and no change; else stack[sp] = imm, sp+1. done pulses the next cycle; state stays IDLE.
  - Operate command: if entries < required, err = 10 with done next cycle, no stack/flag change, stay IDLE. Else go to ISSUE.
- ISSUE (1 cycle):
  - Drive ALU ports.
  - Register alu_result, alu_remainder, all flags and alu_comp at the clock edge.
  - Go to WRITE.
- WRITE:
  - divbyzero captured: stack unchanged, flags updated, err = 11.
  - COMP: comp_flag updated, flags not updated, stack unchanged, err = 00.
  - Otherwise: pop operands, push result in the same cycle.
    - Binary ops: new sp = sp-1, stack[sp-2] = result.
    - Linked ops and NOT: stack[sp-1] = result.
  - Assert done; return to IDLE.
- Latency: operate command accepted at cycle N → done at N+2; push command → done at N+1.
- cmd_ready is low in ISSUE and WRITE; the command source must hold cmd_valid.
- Results wrap modulo 256; flags report the condition, but the result is still written back.
- Reset mid-operation: returns to IDLE immediately with sp = 0; the in-flight command is dropped and done is not asserted.

Optional Feature:
ALU_REMAINDER_PUSH_EN
- Defined: for div/divi with no error, the remainder is also pushed above the quotient.
  - div: stack[sp-2] = quotient, stack[sp-1] = remainder, sp unchanged.
  - divi: needs one free slot checked in IDLE; if none, err = 01 and no issue.
- Undefined: the remainder is discarded; only the quotient is written.

Test Plan:
- Push 5, push 3, op 0000 → done at N+2, depth_cnt = 1, TOP = 8, flags = 0000, err = 00.
- Push 2, op 1101 imm 0 → err = 11, flags.divbyzero = 1, depth_cnt = 1, TOP = 2.
- Push DEPTH values, then push again → err = 01, depth_cnt = DEPTH; op 0000 on an empty stack → err = 10.
- Push 7, push 7, op 1111 → comp_flag = 01, depth_cnt = 2; push 9, push 4, op 0010 → TOP = 5, zero = 0.
- Push 17, push 5, op 1100 → macro defined: stack holds 3 then 2 (TOP = 2), depth 2; macro undefined: TOP = 3, depth 1.
- Assert rst_n low during ISSUE → next cycle depth_cnt = 0, done = 0, cmd_ready = 1.

Source files
------------

// File: rtl/alu_stack_issuer.sv
// alu_stack_issuer: operand-stack front end for the nanoRisc arithmeticUnit.
// Push commands load the 8-bit stack; operate commands issue operands and an
// opcode to the combinational ALU and write the captured result back.
// Optional build feature: define ALU_REMAINDER_PUSH_EN to also push the
// div/divi remainder above the quotient (default: remainder discarded).
//
// Command handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; the source holds
// cmd_valid and the command fields stable until the transfer. Each accepted
// command retires with exactly one done pulse (err valid in that cycle),
// unless reset intervenes.
module alu_stack_issuer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_push,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_imm,
  input  logic             cmd_unsigned,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_unsigned,
  input  logic [7:0]       alu_result,
  input  logic [7:0]       alu_remainder,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_underflow,
  input  logic             alu_divbyzero,
  input  logic [1:0]       alu_comp,
  output logic             done,
  output logic [1:0]       err,
  output logic [3:0]       flags,
  output logic [1:0]       comp_flag,
  output logic [PTR_W:0]   depth_cnt,
  output logic [1:0]       dbg_state
);

`ifdef ALU_REMAINDER_PUSH_EN
  localparam bit REM_PUSH = 1'b1;
`else
  localparam bit REM_PUSH = 1'b0;
`endif

  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVI = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_COMP = 4'b1111;

  localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] SP_TWO  = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  // Linked ops take TOP plus the registered immediate.
  function automatic logic is_linked(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0011) || (op == 4'b1011) || (op == OP_DIVI);
  endfunction

  // Single-stack-operand ops: linked ops and NOT.
  function automatic logic is_unary(input logic [3:0] op);
    return is_linked(op) || (op == OP_NOT);
  endfunction

  state_e           state_q, state_d;
  logic [PTR_W:0]   sp_q, sp_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       imm_q, imm_d;
  logic             uns_q, uns_d;
  logic [7:0]       res_q, res_d;
  logic [7:0]       rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [3:0]       flags_q, flags_d;
  logic [1:0]       comp_q, comp_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;

  logic [7:0]       stack_q [DEPTH];
  logic             we0, we1;
  logic [PTR_W-1:0] wa0, wa1;
  logic [7:0]       wd0, wd1;

  logic [PTR_W-1:0] top_idx, next_idx;
  logic [7:0]       top_val, next_val;
  logic [PTR_W:0]   need;

  assign top_idx  = PTR_W'(sp_q - SP_ONE);
  assign next_idx = PTR_W'(sp_q - SP_TWO);
  assign top_val  = stack_q[top_idx];
  assign next_val = stack_q[next_idx];
  assign need     = is_unary(cmd_op) ? SP_ONE : SP_TWO;

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q | (state_q == S_WRITE);
  assign err       = (state_q == S_WRITE) ? (dbz_q ? 2'b11 : 2'b00) : err_q;
  assign flags     = flags_q;
  assign comp_flag = comp_q;
  assign depth_cnt = sp_q;
  assign dbg_state = state_q;

  // Control and capture registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      op_q    <= '0;
      imm_q   <= '0;
      uns_q   <= 1'b0;
      res_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      flags_q <= '0;
      comp_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      uns_q   <= uns_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      flags_q <= flags_d;
      comp_q  <= comp_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Stack storage: contents are not reset, only the pointer is.
  always_ff @(posedge clk) begin
    if (we0) stack_q[wa0] <= wd0;
    if (we1) stack_q[wa1] <= wd1;
  end

  // Next-state, stack writes and ALU drive.
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    op_d         = op_q;
    imm_d        = imm_q;
    uns_d        = uns_q;
    res_d        = res_q;
    rem_d        = rem_q;
    dbz_d        = dbz_q;
    flags_d      = flags_q;
    comp_d       = comp_q;
    done_d       = 1'b0;
    err_d        = 2'b00;
    we0          = 1'b0;
    wa0          = '0;
    wd0          = '0;
    we1          = 1'b0;
    wa1          = '0;
    wd1          = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = '0;
    alu_unsigned = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          imm_d = cmd_imm;
          uns_d = cmd_unsigned;
          if (cmd_push) begin
            done_d = 1'b1;
            if (sp_q == SP_FULL) begin
              err_d = 2'b01;
            end else begin
              we0  = 1'b1;
              wa0  = sp_q[PTR_W-1:0];
              wd0  = cmd_imm;
              sp_d = sp_q + SP_ONE;
            end
          end else if (sp_q < need) begin
            done_d = 1'b1;
            err_d  = 2'b10;
          end else if (REM_PUSH && (cmd_op == OP_DIVI) && (sp_q == SP_FULL)) begin
            // No free slot for the remainder: refuse before issuing.
            done_d = 1'b1;
            err_d  = 2'b01;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        alu_op       = op_q;
        alu_unsigned = uns_q;
        if (is_unary(op_q)) begin
          alu_a = top_val;
          alu_b = is_linked(op_q) ? imm_q : 8'h00;
        end else begin
          alu_a = next_val;
          alu_b = top_val;
        end
        res_d = alu_result;
        rem_d = alu_remainder;
        dbz_d = alu_divbyzero;
        if (op_q == OP_COMP) comp_d = alu_comp;
        else flags_d = {alu_zero, alu_overflow, alu_underflow, alu_divbyzero};
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (!dbz_q && (op_q != OP_COMP)) begin
          if (is_unary(op_q)) begin
            we0 = 1'b1;
            wa0 = top_idx;
            wd0 = res_q;
            if (REM_PUSH && (op_q == OP_DIVI)) begin
              we1  = 1'b1;
              wa1  = sp_q[PTR_W-1:0];
              wd1  = rem_q;
              sp_d = sp_q + SP_ONE;
            end
          end else begin
            we0  = 1'b1;
            wa0  = next_idx;
            wd0  = res_q;
            sp_d = sp_q - SP_ONE;
            if (REM_PUSH && (op_q == OP_DIV)) begin
              we1  = 1'b1;
              wa1  = top_idx;
              wd1  = rem_q;
              sp_d = sp_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
